fetch_sequencer: RTL

Control FSM that owns program-counter sequencing for the fetch stage. Boots the PC from the reset vector in instruction memory, picks the next PC source each cycle (increment, hold, jump, write-back return), and runs the interrupt entry sequence: drain, save PC, load interrupt vector. Sits between the hazard/branch logic and the PC register and instruction memory address port of the fetch stage.

---
 rtl/fetch_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC source selection, reset-vector boot and interrupt entry for the fetch stage.
// Interrupt entry (drain, save PC, vector load) is compiled in only when FETCH_SEQ_INT_EN is defined.
module fetch_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        StallReq,
  input  logic        JmpTaken,
  input  logic [31:0] JmpTarget,
  input  logic        RetRti,
  input  logic [31:0] WbPc,
  input  logic        IntReq,
  input  logic [31:0] PcIn,
  input  logic [15:0] ImemData,
  output logic [2:0]  PcSel,
  output logic [31:0] PcLoadData,
  output logic        ImemAddrSel,
  output logic [31:0] ImemVecAddr,
  output logic        FlushFD,
  output logic        IntAck,
  output logic [31:0] SavePc,
  output logic        Busy
);

  typedef enum logic [2:0] {
    BOOT_LO   = 3'd0,
    BOOT_HI   = 3'd1,
    LOAD      = 3'd2,
    RUN       = 3'd3,
    INT_DRAIN = 3'd4,
    INT_LO    = 3'd5,
    INT_HI    = 3'd6
  } state_t;

  localparam logic [2:0] SEL_HOLD = 3'd0;
  localparam logic [2:0] SEL_INC  = 3'd1;
  localparam logic [2:0] SEL_JMP  = 3'd2;
  localparam logic [2:0] SEL_WB   = 3'd3;
  localparam logic [2:0] SEL_VEC  = 3'd4;

  state_t      state_q;
  logic [15:0] lo_q;
  logic [15:0] hi_q;
  logic        pend_s;

`ifdef FETCH_SEQ_INT_EN
  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);

  logic        pending_q;
  logic [2:0]  drain_q;
  logic [31:0] save_q;
  logic        in_entry_s;

  assign pend_s     = pending_q;
  // Requests arriving while an entry is already under way fold into it.
  assign in_entry_s = (state_q == INT_DRAIN) || (state_q == INT_LO) || (state_q == INT_HI);
  assign SavePc     = save_q;
`else
  logic unused_s;

  assign pend_s   = 1'b0;
  assign SavePc   = 32'd0;
  assign unused_s = ^{IntReq, JmpTarget, WbPc, PcIn};
`endif

  assign PcLoadData = {hi_q, lo_q};
  assign Busy       = (state_q != RUN);

  // PC source, flush and vector-fetch controls decoded from state and redirect inputs.
  always_comb begin
    PcSel       = SEL_HOLD;
    FlushFD     = 1'b0;
    ImemAddrSel = 1'b0;
    ImemVecAddr = 32'd0;
    IntAck      = 1'b0;
    case (state_q)
      BOOT_LO:   begin ImemAddrSel = 1'b1; FlushFD = 1'b1; ImemVecAddr = 32'd0; end
      BOOT_HI:   begin ImemAddrSel = 1'b1; FlushFD = 1'b1; ImemVecAddr = 32'd1; end
      INT_LO:    begin ImemAddrSel = 1'b1; FlushFD = 1'b1; ImemVecAddr = 32'd2; end
      INT_HI:    begin ImemAddrSel = 1'b1; FlushFD = 1'b1; ImemVecAddr = 32'd3; end
      LOAD:      begin PcSel = SEL_VEC; FlushFD = 1'b1; end
      INT_DRAIN: begin FlushFD = 1'b1; end
      RUN: begin
        if (RetRti) begin
          PcSel   = SEL_WB;
          FlushFD = 1'b1;
        end else if (JmpTaken) begin
          PcSel   = SEL_JMP;
          FlushFD = 1'b1;
        end else if (StallReq) begin
          PcSel = SEL_HOLD;
        end else if (pend_s) begin
          PcSel  = SEL_HOLD;
          IntAck = 1'b1;
        end else begin
          PcSel = SEL_INC;
        end
      end
      default: begin FlushFD = 1'b1; end
    endcase
  end

  // Sequencer state, captured vector halves and interrupt bookkeeping.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= BOOT_LO;
      lo_q      <= 16'd0;
      hi_q      <= 16'd0;
`ifdef FETCH_SEQ_INT_EN
      pending_q <= 1'b0;
      drain_q   <= 3'd0;
      save_q    <= 32'd0;
`endif
    end else begin
      case (state_q)
        BOOT_LO: begin lo_q <= ImemData; state_q <= BOOT_HI; end
        BOOT_HI: begin hi_q <= ImemData; state_q <= LOAD; end
        LOAD:    begin state_q <= RUN; end
`ifdef FETCH_SEQ_INT_EN
        RUN: begin
          if (IntAck) begin
            save_q  <= PcIn;
            drain_q <= DRAIN_INIT;
            state_q <= INT_DRAIN;
          end else begin
            state_q <= RUN;
          end
        end
        INT_DRAIN: begin
          // An older instruction still resolving a redirect owns the return address.
          if (RetRti) begin
            save_q <= WbPc;
          end else if (JmpTaken) begin
            save_q <= JmpTarget;
          end else begin
            save_q <= save_q;
          end
          if (drain_q == 3'd0) begin
            state_q <= INT_LO;
          end else begin
            drain_q <= drain_q - 3'd1;
          end
        end
        INT_LO: begin lo_q <= ImemData; state_q <= INT_HI; end
        INT_HI: begin hi_q <= ImemData; state_q <= LOAD; end
`else
        RUN:     begin state_q <= RUN; end
`endif
        default: begin state_q <= BOOT_LO; end
      endcase
`ifdef FETCH_SEQ_INT_EN
      if (IntAck) begin
        pending_q <= 1'b0;
      end else if (IntReq && !in_entry_s) begin
        pending_q <= 1'b1;
      end else begin
        pending_q <= pending_q;
      end
`endif
    end
  end

endmodule
